// File: rtl/conv_pkg.sv
// Shared types and defaults for the 1-D convolution engine.
// The saturate helper clamps a wide accumulator to an unsigned z_w-bit range.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MAC,
    DRAIN,
    WRITE,
    FINISH
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_Z_W    = 16;

  function automatic logic [63:0] saturate(input logic [63:0] acc, input int z_w);
    logic [63:0] max_val;
    max_val = (z_w >= 64) ? {64{1'b1}} : ((64'd1 << z_w) - 64'd1);
    return (acc > max_val) ? max_val : acc;
  endfunction

endpackage

// File: rtl/conv1d_engine_if.sv
// Controller handshake plus the three external memory ports of conv1d_engine.
// master = the engine, slave = controller/memory side.
interface conv1d_engine_if #(
  parameter int DATA_W = conv_pkg::DEF_DATA_W,
  parameter int ADDR_W = conv_pkg::DEF_ADDR_W,
  parameter int Z_W    = conv_pkg::DEF_Z_W
);
  logic              start;
  logic [ADDR_W-1:0] sizeX;
  logic [ADDR_W-1:0] sizeY;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] memX_addr;
  logic              memX_rd;
  logic [DATA_W-1:0] memX_data;
  logic [ADDR_W-1:0] memY_addr;
  logic              memY_rd;
  logic [DATA_W-1:0] memY_data;
  logic [ADDR_W-1:0] memZ_addr;
  logic              memZ_wr;
  logic [Z_W-1:0]    memZ_data;

  modport master (
    input  start, sizeX, sizeY, memX_data, memY_data,
    output busy, done, err, memX_addr, memX_rd, memY_addr, memY_rd,
           memZ_addr, memZ_wr, memZ_data
  );

  modport slave (
    output start, sizeX, sizeY, memX_data, memY_data,
    input  busy, done, err, memX_addr, memX_rd, memY_addr, memY_rd,
           memZ_addr, memZ_wr, memZ_data
  );
endinterface

// File: rtl/conv_mac.sv
// Unsigned multiply-accumulate; valid_in marks a read issued this cycle whose
// operands arrive next cycle, so the product is added one cycle later.
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              hold,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic                valid_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;
  assign acc  = acc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      acc_reg   <= '0;
    end else begin
      valid_reg <= valid_in;
      if (clear)
        acc_reg <= '0;
      else if (valid_reg && !hold)
        acc_reg <= acc_reg + ACC_W'(prod);
    end
  end
endmodule

// File: rtl/conv1d_engine.sv
// Direct-form 1-D convolution Z[i] = sum_j Y[j]*X[i-j] over external memories.
// FSM and index counters live here; the MAC datapath is in conv_mac.
module conv1d_engine
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ACC_W    = 2*DATA_W + ADDR_W,
  parameter int Z_W      = DEF_Z_W,
  parameter int SATURATE = 1
) (
  input logic             clk,
  input logic             reset,
  conv1d_engine_if.master bus
);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_reg;
  logic [ADDR_W-1:0] sx_reg, sy_reg, i_reg, j_reg;
  logic              busy_reg, done_reg, err_reg;
  logic [ADDR_W:0]   job_len, last_i;
  logic              bad_size, term_valid;
  logic [ACC_W-1:0]  acc;
  logic [Z_W-1:0]    z_word;

  assign job_len  = {1'b0, sx_reg} + {1'b0, sy_reg} - (ADDR_W+1)'(1);
  assign last_i   = job_len - (ADDR_W+1)'(1);
  assign bad_size = (sx_reg == '0) || (sy_reg == '0) || (job_len > MAX_LEN);
  // Only taps with 0 <= i-j < sizeX touch memory; the rest contribute zero.
  assign term_valid = (state_reg == MAC) && (i_reg >= j_reg) && ((i_reg - j_reg) < sx_reg);

  conv_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state_reg == CHECK) || (state_reg == WRITE)),
    .hold     (!((state_reg == MAC) || (state_reg == DRAIN))),
    .valid_in (term_valid),
    .a        (bus.memX_data),
    .b        (bus.memY_data),
    .acc      (acc)
  );

  always_comb begin
    z_word = (SATURATE != 0) ? Z_W'(saturate(64'(acc), Z_W)) : Z_W'(acc);
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.memX_rd   = term_valid;
  assign bus.memX_addr = i_reg - j_reg;
  assign bus.memY_rd   = term_valid;
  assign bus.memY_addr = j_reg;
  assign bus.memZ_wr   = (state_reg == WRITE);
  assign bus.memZ_addr = i_reg;
  assign bus.memZ_data = z_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sx_reg    <= '0;
      sy_reg    <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (bus.start) begin
          sx_reg    <= bus.sizeX;
          sy_reg    <= bus.sizeY;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b1;
          state_reg <= CHECK;
        end
        CHECK: if (bad_size) begin
          err_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= FINISH;
        end else begin
          i_reg     <= '0;
          j_reg     <= '0;
          state_reg <= MAC;
        end
        MAC: if (j_reg == sy_reg - ADDR_W'(1))
          state_reg <= DRAIN;
        else
          j_reg <= j_reg + ADDR_W'(1);
        DRAIN: state_reg <= WRITE;
        WRITE: begin
          j_reg <= '0;
          if ({1'b0, i_reg} == last_i) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end else begin
            i_reg     <= i_reg + ADDR_W'(1);
            state_reg <= MAC;
          end
        end
        FINISH:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv1d_engine.sv
// Directed bench: two engines (saturating and wrapping, Z_W=8) share stimulus
// and memory contents; results are checked against hand-computed tables.
module tb_conv1d_engine;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int ZW = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [AW-1:0] size_x, size_y;
  logic cap_clr;

  always #5 clk = ~clk;

  conv1d_engine_if #(.DATA_W(DW), .ADDR_W(AW), .Z_W(ZW)) ifa ();
  conv1d_engine_if #(.DATA_W(DW), .ADDR_W(AW), .Z_W(ZW)) ifb ();

  conv1d_engine #(.DATA_W(DW), .ADDR_W(AW), .Z_W(ZW), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .bus(ifa));
  conv1d_engine #(.DATA_W(DW), .ADDR_W(AW), .Z_W(ZW), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .bus(ifb));

  logic [DW-1:0] mem_x [32];
  logic [DW-1:0] mem_y [32];
  logic [DW-1:0] xa_q, ya_q, xb_q, yb_q;
  logic [ZW-1:0] za [32];
  logic [ZW-1:0] zb [32];
  int wcnt, en_cnt, done_cnt, last_addr;

  assign ifa.start = start;  assign ifb.start = start;
  assign ifa.sizeX = size_x; assign ifb.sizeX = size_x;
  assign ifa.sizeY = size_y; assign ifb.sizeY = size_y;
  assign ifa.memX_data = xa_q; assign ifa.memY_data = ya_q;
  assign ifb.memX_data = xb_q; assign ifb.memY_data = yb_q;

  // Synchronous read memories plus a write/enable/done recorder.
  always @(posedge clk) begin
    if (ifa.memX_rd) xa_q <= mem_x[ifa.memX_addr];
    if (ifa.memY_rd) ya_q <= mem_y[ifa.memY_addr];
    if (ifb.memX_rd) xb_q <= mem_x[ifb.memX_addr];
    if (ifb.memY_rd) yb_q <= mem_y[ifb.memY_addr];
    if (cap_clr) begin
      wcnt <= 0; en_cnt <= 0; done_cnt <= 0; last_addr <= 0;
      for (int n = 0; n < 32; n++) begin za[n] <= '0; zb[n] <= '0; end
    end else begin
      if (ifa.memZ_wr) begin
        za[ifa.memZ_addr] <= ifa.memZ_data;
        wcnt      <= wcnt + 1;
        last_addr <= int'(ifa.memZ_addr);
      end
      if (ifb.memZ_wr) zb[ifb.memZ_addr] <= ifb.memZ_data;
      if (ifa.memX_rd || ifa.memY_rd || ifa.memZ_wr) en_cnt <= en_cnt + 1;
      if (ifa.done) done_cnt <= done_cnt + 1;
    end
  end

  typedef struct packed {
    int              sx;
    int              sy;
    logic [3:0][7:0] x;   // x[0] in the low byte
    logic [3:0][7:0] y;
    logic [4:0][7:0] zs;  // expected saturating result, z[0] in the low byte
    logic [4:0][7:0] zw;  // expected wrapping result
    int              nw;
    int              e;
    int              dc;
  } vec_t;

  vec_t tbl [8];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_a();
    return int'({ifa.busy, ifa.done, ifa.err, ifa.memX_rd, ifa.memY_rd, ifa.memZ_wr,
                 ifa.memX_addr, ifa.memY_addr, ifa.memZ_addr, ifa.memZ_data});
  endfunction

  task automatic clear_cap();
    @(negedge clk); cap_clr = 1'b1;
    @(negedge clk); cap_clr = 1'b0;
  endtask

  task automatic load_vec(input int v);
    for (int n = 0; n < 32; n++) begin
      mem_x[n] = (n < 4) ? tbl[v].x[n] : 8'd0;
      mem_y[n] = (n < 4) ? tbl[v].y[n] : 8'd0;
    end
  endtask

  // Launch one job; dc = cycle of the done pulse counted from the accept cycle.
  task automatic run_job(input int sx, input int sy, input int intr, output int dc);
    int cyc;
    clear_cap();
    start = 1'b1; size_x = AW'(sx); size_y = AW'(sy);
    @(negedge clk);
    start = 1'b0; size_x = AW'(~sx); size_y = AW'(sy + 3);
    cyc = 1; dc = -1;
    while (cyc < 2000) begin
      if (cyc == 1) chk("busy_cycle1", int'(ifa.busy), 1);
      if (ifa.done) begin dc = cyc; break; end
      @(negedge clk); cyc++;
      start = (cyc == intr);
    end
    start = 1'b0;
    if (dc < 0) chk("done_timeout", 0, 1);
    else chk("busy_at_done", int'(ifa.busy), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(ifa.done), 0);
    @(negedge clk);
  endtask

  task automatic check_vec(input int v, input int dc);
    chk($sformatf("v%0d_done_cycle", v), dc, tbl[v].dc);
    chk($sformatf("v%0d_err", v), int'(ifa.err), tbl[v].e);
    chk($sformatf("v%0d_writes", v), wcnt, tbl[v].nw);
    chk($sformatf("v%0d_done_count", v), done_cnt, 1);
    if (tbl[v].e != 0) chk($sformatf("v%0d_mem_enables", v), en_cnt, 0);
    for (int n = 0; n < tbl[v].nw; n++) begin
      chk($sformatf("v%0d_zsat[%0d]", v, n), int'(za[n]), int'(tbl[v].zs[n]));
      chk($sformatf("v%0d_zwrap[%0d]", v, n), int'(zb[n]), int'(tbl[v].zw[n]));
    end
    $display("job v%0d sx=%0d sy=%0d done_cycle=%0d writes=%0d err=%0d",
             v, tbl[v].sx, tbl[v].sy, dc, wcnt, ifa.err);
  endtask

  initial begin
    int dc, cyc, exp_z;
    tbl[0] = '{sx:4,  sy:2,  x:32'h04030201, y:32'h00000101, zs:40'h0407050301, zw:40'h0407050301, nw:5, e:0, dc:22};
    tbl[1] = '{sx:2,  sy:2,  x:32'h0000FFFF, y:32'h0000FFFF, zs:40'h0000FFFFFF, zw:40'h0000010201, nw:3, e:0, dc:14};
    tbl[2] = '{sx:3,  sy:0,  x:32'h00030201, y:32'h00000101, zs:40'h0,          zw:40'h0,          nw:0, e:1, dc:2};
    tbl[3] = '{sx:1,  sy:1,  x:32'h00000007, y:32'h00000009, zs:40'h000000003F, zw:40'h000000003F, nw:1, e:0, dc:5};
    tbl[4] = '{sx:3,  sy:3,  x:32'h00010002, y:32'h00020103, zs:40'h0201070206, zw:40'h0201070206, nw:5, e:0, dc:27};
    tbl[5] = '{sx:0,  sy:2,  x:32'h00000001, y:32'h00000101, zs:40'h0,          zw:40'h0,          nw:0, e:1, dc:2};
    tbl[6] = '{sx:1,  sy:3,  x:32'h00000005, y:32'h00030201, zs:40'h00000F0A05, zw:40'h00000F0A05, nw:3, e:0, dc:17};
    tbl[7] = '{sx:20, sy:14, x:32'h01010101, y:32'h01010101, zs:40'h0,          zw:40'h0,          nw:0, e:1, dc:2};

    reset = 1'b0; start = 1'b0; size_x = '0; size_y = '0; cap_clr = 1'b0;
    #1;
    chk("reset_outputs", outs_a(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      load_vec(v);
      run_job(tbl[v].sx, tbl[v].sy, 0, dc);
      check_vec(v, dc);
    end

    // Start pulse mid-job with different sizes must be ignored.
    load_vec(0);
    run_job(4, 2, 7, dc);
    check_vec(0, dc);

    // Asynchronous reset during MAC of output 2 (cycle 10).
    load_vec(0);
    clear_cap();
    start = 1'b1; size_x = 5'd4; size_y = 5'd2;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    chk("pre_reset_memx_rd", int'(ifa.memX_rd), 1);
    reset = 1'b0;
    #1;
    chk("midjob_reset_outputs", outs_a(), 0);
    chk("midjob_writes_before", wcnt, 2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("midjob_no_done", done_cnt, 0);
    chk("midjob_no_more_writes", wcnt, 2);
    $display("job midjob_reset writes=%0d done_count=%0d", wcnt, done_cnt);
    run_job(4, 2, 0, dc);
    check_vec(0, dc);

    // Largest legal output length: 31 + 2 - 1 = 32 writes.
    for (int n = 0; n < 32; n++) begin
      mem_x[n] = (n < 31) ? 8'(n + 1) : 8'd0;
      mem_y[n] = (n < 2) ? 8'd1 : 8'd0;
    end
    run_job(31, 2, 0, dc);
    chk("max_done_cycle", dc, 130);
    chk("max_writes", wcnt, 32);
    chk("max_last_addr", last_addr, 31);
    chk("max_err", int'(ifa.err), 0);
    for (int n = 0; n < 32; n++) begin
      exp_z = (n == 0) ? 1 : (n == 31) ? 31 : 2*n + 1;
      chk($sformatf("max_z[%0d]", n), int'(za[n]), exp_z);
    end
    $display("job max sx=31 sy=2 done_cycle=%0d writes=%0d last_addr=%0d", dc, wcnt, last_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv1d_engine.md
Name: conv1d_engine

Overview:
- Parametrised 1-D direct-form convolution engine: Z[i] = sum over j of Y[j]*X[i-j], for i = 0 .. sizeX+sizeY-2.
- Successor to the fixed 8-bit, 3-bit-address convolution FSM. Adds runtime lengths, a start/busy/done handshake, a pipelined MAC, error detection and an optional saturating output.
- Sits between a controller and three external synchronous memories (memX signal, memY kernel, memZ result). Drives their address/enable ports; holds no sample storage itself.

Parameters:
- DATA_W, 8, width of X and Y samples (unsigned).
- ADDR_W, 5, address width of memX/memY/memZ.
- ACC_W, 2*DATA_W+ADDR_W, accumulator width; never overflows for legal sizes.
- Z_W, 16, width of the memZ write word.
- SATURATE, 1, 1 = clamp result to 2^Z_W-1; 0 = keep low Z_W bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- sizeX  in  ADDR_W  X length; sampled with start.
- sizeY  in  ADDR_W  Y length; sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of job.
- err  out  1  registered error flag; cleared on the next accepted start.
- memX_addr  out  ADDR_W  X read address.
- memX_rd  out  1  X read enable.
- memX_data  in  DATA_W  X data, valid 1 cycle after memX_rd.
- memY_addr  out  ADDR_W  Y read address.
- memY_rd  out  1  Y read enable.
- memY_data  in  DATA_W  Y data, valid 1 cycle after memY_rd.
- memZ_addr  out  ADDR_W  Z write address.
- memZ_wr  out  1  Z write enable.
- memZ_data  out  Z_W  Z write data.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including busy, done, err, addresses, enables and memZ_data; counters 0.
- States: IDLE, CHECK, MAC, DRAIN, WRITE, FINISH.
- IDLE: on start, latch sizeX/sizeY, clear err, go to CHECK.
- start while not IDLE is ignored. sizeX/sizeY changes after the latch cycle are ignored.
- CHECK (1 cycle): sizeX==0 or sizeY==0 or sizeX+sizeY-1 > 2^ADDR_W sets err=1 and goes to FINISH with no memory access. Otherwise i=0, j=0, acc=0, go to MAC.
- MAC (sizeY cycles per output): each cycle computes k=i-j.
  - If 0 <= k < sizeX: assert memX_rd with addr k and memY_rd with addr j.
  - Otherwise: no reads, and the term contributes 0.
  - A one-cycle-delayed valid flag adds memX_data*memY_data to acc.
  - j increments each cycle; after j==sizeY-1, go to DRAIN.
- DRAIN (1 cycle): the last product is accumulated.
- WRITE (1 cycle):
  - memZ_wr=1, memZ_addr=i.
  - memZ_data = acc clamped (SATURATE=1) or acc[Z_W-1:0] (SATURATE=0).
  - acc and j clear. If i == sizeX+sizeY-2, go to FINISH; else i+1, back to MAC.
- FINISH (1 cycle): done=1, busy drops the same cycle, return to IDLE.
- Enables are high only in the cycles stated above; addresses may hold their last value otherwise.
- Cycle count for a legal job: start accepted at cycle 0, CHECK at 1, first MAC at 2. done asserts at cycle 2 + (sizeX+sizeY-1)*(sizeY+2).
- Multiplier is DATA_W x DATA_W unsigned, zero-extended to ACC_W.
- Reset mid-job: immediate return to IDLE, no further writes, no done pulse; the partial memZ contents are undefined.
- sizeY==1 and sizeX==1 is legal: one output, Z[0]=X[0]*Y[0].

Decomposition:
- Package conv_pkg: state enum typedef, default widths, and a saturate function (acc, Z_W) -> Z_W.
- One sub-module, conv_mac: multiplier plus accumulator with valid-delay register, clear and hold inputs.
- The FSM and index counters stay in conv1d_engine.

Test Plan:
- Basic job: X={1,2,3,4}, Y={1,1}, sizeX=4, sizeY=2 -> Z={1,3,5,7,4} at addr 0..4, exactly 5 memZ_wr pulses, done at cycle 22.
- Saturation, DATA_W=8, Z_W=8: X={255,255}, Y={255,255} -> SATURATE=1 writes {255,255,255}; SATURATE=0 writes {1,2,1} (low 8 bits of 65025, 130050, 65025).
- Errors: sizeY=0 -> err=1 and done pulse at cycle 2, zero memory enables. A following legal start clears err.
- Ignored start: a start pulse in the middle of a busy job -> no effect; Z is identical to the single-job result and there is only one done.
- Reset mid-job: assert reset in MAC of output i=2 -> all outputs 0 asynchronously, no done. After release, a new job runs correctly.
- Edge sizes: sizeX=1, sizeY=1, X={7}, Y={9} -> single write Z[0]=63, done at cycle 5. Also max legal sizeX+sizeY-1=32 with ADDR_W=5 -> 32 writes, last at addr 31.
